// File: rtl/uart_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// uart_buffer_ctrl
// TX/RX data buffering between the UART register file and the protocol
// engines. Two synchronous FIFOs, each with flush, sticky overflow/underflow
// flags and a watermark interrupt, plus an optional RX character-timeout
// detector.
//
// Optional feature macro: UART_BUF_RX_TIMEOUT_EN
//   defined   -> RX idle counter and int_rx_timeout are built
//   undefined -> int_rx_timeout tied low, rx_tmo_cycles / rx_tmo_clr ignored
//
// Ports
//   clk, rstn                 clock, async active-low reset
//   tx_flush / rx_flush       empty the FIFO (single-cycle pulse)
//   tx_we, tx_wdata           TX write side (register file)
//   tx_re, tx_rdata           TX read side (TX engine), rdata 1-cycle latency
//   rx_we, rx_wdata           RX write side (RX engine)
//   rx_re, rx_rdata           RX read side (register file)
//   tx_level / rx_level       occupancy 0..2**ADDR_WIDTH
//   tx/rx_empty, tx/rx_full   status flags
//   tx/rx_watermark           warning thresholds
//   err_clr, err_status       W1C / sticky {rx_udf, rx_ovf, tx_udf, tx_ovf}
//   rx_tmo_cycles, rx_tmo_clr RX timeout threshold (0 = off) and flag clear
//   int_*                     level interrupt status
// -----------------------------------------------------------------------------

// Single synchronous FIFO used for both directions.
// Ports: clk/rstn, flush, we/wdata, re/rdata, level/empty/full,
//        wr_acc/rd_acc (accepted ops), ovf_evt/udf_evt (error strobes).
module uart_buf_fifo #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  we,
    input  logic                  re,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  empty,
    output logic                  full,
    output logic                  wr_acc,
    output logic                  rd_acc,
    output logic                  ovf_evt,
    output logic                  udf_evt
);
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;

    assign empty = (level == '0);
    assign full  = (level == DEPTH);

    // Flush wins over everything and suppresses error reporting that cycle.
    assign rd_acc  = re & ~empty & ~flush;
    assign wr_acc  = we & (~full | rd_acc) & ~flush;
    assign ovf_evt = we & full & ~rd_acc & ~flush;
    assign udf_evt = re & empty & ~flush;

    // Storage is deliberately not reset; only pointers and level are.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            rdata <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr_acc)
                wptr <= wptr + 1'b1;
            if (rd_acc) begin
                rptr  <= rptr + 1'b1;
                rdata <= mem[rptr];
            end
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

module uart_buffer_ctrl #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 4,
    parameter int TMO_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  tx_flush,
    input  logic                  rx_flush,
    input  logic                  tx_we,
    input  logic                  rx_we,
    input  logic                  tx_re,
    input  logic                  rx_re,
    input  logic [DATA_WIDTH-1:0] tx_wdata,
    input  logic [DATA_WIDTH-1:0] rx_wdata,
    output logic [DATA_WIDTH-1:0] tx_rdata,
    output logic [DATA_WIDTH-1:0] rx_rdata,
    output logic [ADDR_WIDTH:0]   tx_level,
    output logic [ADDR_WIDTH:0]   rx_level,
    output logic                  tx_empty,
    output logic                  tx_full,
    output logic                  rx_empty,
    output logic                  rx_full,
    input  logic [ADDR_WIDTH:0]   tx_watermark,
    input  logic [ADDR_WIDTH:0]   rx_watermark,
    input  logic [3:0]            err_clr,
    output logic [3:0]            err_status,
    input  logic [TMO_WIDTH-1:0]  rx_tmo_cycles,
    input  logic                  rx_tmo_clr,
    output logic                  int_rx_noempty,
    output logic                  int_rx_warning,
    output logic                  int_tx_empty,
    output logic                  int_tx_warning,
    output logic                  int_rx_timeout
);
    logic tx_wr_acc, tx_rd_acc, tx_ovf, tx_udf;
    logic rx_wr_acc, rx_rd_acc, rx_ovf, rx_udf;

    uart_buf_fifo #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_tx_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .flush   (tx_flush),
        .we      (tx_we),
        .re      (tx_re),
        .wdata   (tx_wdata),
        .rdata   (tx_rdata),
        .level   (tx_level),
        .empty   (tx_empty),
        .full    (tx_full),
        .wr_acc  (tx_wr_acc),
        .rd_acc  (tx_rd_acc),
        .ovf_evt (tx_ovf),
        .udf_evt (tx_udf)
    );

    uart_buf_fifo #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rx_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .flush   (rx_flush),
        .we      (rx_we),
        .re      (rx_re),
        .wdata   (rx_wdata),
        .rdata   (rx_rdata),
        .level   (rx_level),
        .empty   (rx_empty),
        .full    (rx_full),
        .wr_acc  (rx_wr_acc),
        .rd_acc  (rx_rd_acc),
        .ovf_evt (rx_ovf),
        .udf_evt (rx_udf)
    );

    // Sticky errors: a new event in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            err_status <= '0;
        else
            err_status <= (err_status & ~err_clr) | {rx_udf, rx_ovf, tx_udf, tx_ovf};
    end

    assign int_rx_noempty = ~rx_empty;
    assign int_tx_empty   = tx_empty;
    assign int_rx_warning = (rx_level >= rx_watermark);
    // TX warning is a refill request, hence the opposite comparison.
    assign int_tx_warning = (tx_level <= tx_watermark);

`ifdef UART_BUF_RX_TIMEOUT_EN
    logic [TMO_WIDTH-1:0] idle_cnt;
    logic [TMO_WIDTH-1:0] idle_nxt;
    logic                 cnt_clr;
    logic                 tmo_set;
    logic                 tmo_clr;
    logic                 tmo_flag;

    assign cnt_clr = rx_empty | rx_wr_acc | rx_rd_acc | rx_flush | (rx_tmo_cycles == '0);

    always_comb begin
        idle_nxt = idle_cnt;
        if (cnt_clr)
            idle_nxt = '0;
        else if (idle_cnt != '1)
            idle_nxt = idle_cnt + 1'b1;
    end

    // Compare against the next count so the flag rises exactly N edges after
    // the last clearing event rather than N+1.
    assign tmo_set = ~cnt_clr & (idle_nxt == rx_tmo_cycles);
    assign tmo_clr = rx_tmo_clr | rx_rd_acc | rx_flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idle_cnt <= '0;
            tmo_flag <= 1'b0;
        end else begin
            idle_cnt <= idle_nxt;
            if (tmo_clr)
                tmo_flag <= 1'b0;
            else if (tmo_set)
                tmo_flag <= 1'b1;
        end
    end

    assign int_rx_timeout = tmo_flag;

    logic unused_acc;
    assign unused_acc = tx_wr_acc ^ tx_rd_acc;
`else
    assign int_rx_timeout = 1'b0;

    logic unused_tmo;
    assign unused_tmo = ^{rx_tmo_cycles, rx_tmo_clr, rx_wr_acc, rx_rd_acc, tx_wr_acc, tx_rd_acc};
`endif
endmodule

// File: tb/tb_uart_buffer_ctrl.sv
// Directed bench for uart_buffer_ctrl with ADDR_WIDTH=4 (depth 16).
module tb_uart_buffer_ctrl;
    localparam int DW = 10;
    localparam int AW = 4;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          tx_flush, rx_flush, tx_we, rx_we, tx_re, rx_re;
    logic [DW-1:0] tx_wdata, rx_wdata, tx_rdata, rx_rdata;
    logic [AW:0]   tx_level, rx_level, tx_watermark, rx_watermark;
    logic          tx_empty, tx_full, rx_empty, rx_full;
    logic [3:0]    err_clr, err_status;
    logic [TW-1:0] rx_tmo_cycles;
    logic          rx_tmo_clr;
    logic          int_rx_noempty, int_rx_warning, int_tx_empty, int_tx_warning, int_rx_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    uart_buffer_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TMO_WIDTH(TW)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .tx_flush       (tx_flush),
        .rx_flush       (rx_flush),
        .tx_we          (tx_we),
        .rx_we          (rx_we),
        .tx_re          (tx_re),
        .rx_re          (rx_re),
        .tx_wdata       (tx_wdata),
        .rx_wdata       (rx_wdata),
        .tx_rdata       (tx_rdata),
        .rx_rdata       (rx_rdata),
        .tx_level       (tx_level),
        .rx_level       (rx_level),
        .tx_empty       (tx_empty),
        .tx_full        (tx_full),
        .rx_empty       (rx_empty),
        .rx_full        (rx_full),
        .tx_watermark   (tx_watermark),
        .rx_watermark   (rx_watermark),
        .err_clr        (err_clr),
        .err_status     (err_status),
        .rx_tmo_cycles  (rx_tmo_cycles),
        .rx_tmo_clr     (rx_tmo_clr),
        .int_rx_noempty (int_rx_noempty),
        .int_rx_warning (int_rx_warning),
        .int_tx_empty   (int_tx_empty),
        .int_tx_warning (int_tx_warning),
        .int_rx_timeout (int_rx_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] last_rx;
        rstn = 1'b0;
        tx_flush = 0; rx_flush = 0; tx_we = 0; rx_we = 0; tx_re = 0; rx_re = 0;
        tx_wdata = '0; rx_wdata = '0;
        tx_watermark = 5'd4; rx_watermark = 5'd8;
        err_clr = '0; rx_tmo_cycles = '0; rx_tmo_clr = 0;
        #12;
        chk("rst_tx_empty", 32'(tx_empty), 1);
        chk("rst_rx_empty", 32'(rx_empty), 1);
        chk("rst_tx_level", 32'(tx_level), 0);
        chk("rst_err", 32'(err_status), 0);
        chk("rst_int_tx_empty", 32'(int_tx_empty), 1);
        chk("rst_int_tx_warn", 32'(int_tx_warning), 1);
        chk("rst_int_rx_noempty", 32'(int_rx_noempty), 0);
        chk("rst_tmo", 32'(int_rx_timeout), 0);
        chk("rst_tx_rdata", 32'(tx_rdata), 0);
        @(negedge clk);
        rstn = 1'b1;
        step();

        // TX fill to full
        for (int i = 1; i <= 16; i++) begin
            tx_we = 1; tx_wdata = DW'(i);
            step();
        end
        tx_we = 0;
        chk("tx_full", 32'(tx_full), 1);
        chk("tx_level16", 32'(tx_level), 16);
        chk("tx_warn_full", 32'(int_tx_warning), 0);
        chk("err_none", 32'(err_status), 0);

        // overflow write
        tx_we = 1; tx_wdata = 10'h3FF;
        step();
        tx_we = 0;
        chk("tx_ovf", 32'(err_status), 32'h1);
        chk("tx_level_ovf", 32'(tx_level), 16);

        // drain in order; warning flips when level drops to 4
        for (int r = 1; r <= 16; r++) begin
            tx_re = 1;
            step();
            chk("tx_rd_data", 32'(tx_rdata), r);
            chk("tx_warn", 32'(int_tx_warning), ((16 - r) <= 4) ? 1 : 0);
        end
        tx_re = 0;
        chk("tx_empty_end", 32'(tx_empty), 1);

        err_clr = 4'b0001;
        step();
        err_clr = 0;
        chk("tx_ovf_clr", 32'(err_status), 0);

        // TX underflow
        tx_re = 1;
        step();
        tx_re = 0;
        chk("tx_udf", 32'(err_status), 32'h2);
        chk("tx_udf_hold", 32'(tx_rdata), 32'h010);
        err_clr = 4'b0010;
        step();
        err_clr = 0;
        chk("tx_udf_clr", 32'(err_status), 0);

        // RX fill to 15; rx warning rises on 8th write
        for (int i = 1; i <= 15; i++) begin
            rx_we = 1; rx_wdata = DW'(32'h100 + i - 1);
            step();
            chk("rx_warn_fill", 32'(int_rx_warning), (i >= 8) ? 1 : 0);
        end
        chk("rx_level15", 32'(rx_level), 15);

        // simultaneous read+write across pointer wrap
        for (int k = 0; k < 20; k++) begin
            rx_we = 1; rx_re = 1; rx_wdata = DW'(32'h100 + 15 + k);
            step();
            chk("rx_rw_data", 32'(rx_rdata), 32'h100 + k);
            chk("rx_rw_level", 32'(rx_level), 15);
        end
        rx_we = 0;
        chk("rx_rw_err", 32'(err_status), 0);

        for (int k = 20; k < 35; k++) begin
            rx_re = 1;
            step();
            chk("rx_drain", 32'(rx_rdata), 32'h100 + k);
        end
        rx_re = 0;
        chk("rx_empty_drain", 32'(rx_empty), 1);
        last_rx = 10'h122;

        // RX underflow, set-wins, then clear
        rx_re = 1;
        step();
        rx_re = 0;
        chk("rx_udf", 32'(err_status), 32'h8);
        chk("rx_udf_hold", 32'(rx_rdata), 32'(last_rx));
        rx_re = 1; err_clr = 4'b1000;
        step();
        rx_re = 0;
        chk("rx_udf_setwins", 32'(err_status), 32'h8);
        step();
        err_clr = 0;
        chk("rx_udf_clr", 32'(err_status), 0);

        // flush with concurrent write at level 3
        for (int i = 0; i < 3; i++) begin
            rx_we = 1; rx_wdata = DW'(32'h200 + i);
            step();
        end
        chk("rx_level3", 32'(rx_level), 3);
        rx_flush = 1; rx_wdata = 10'h2AA;
        step();
        rx_flush = 0; rx_we = 0;
        chk("flush_level", 32'(rx_level), 0);
        chk("flush_empty", 32'(rx_empty), 1);
        chk("flush_rdata", 32'(rx_rdata), 32'(last_rx));
        step();
        chk("flush_no_ovf", 32'(err_status), 0);
        rx_we = 1; rx_wdata = 10'h055;
        step();
        rx_we = 0; rx_re = 1;
        step();
        rx_re = 0;
        chk("post_flush_data", 32'(rx_rdata), 32'h055);
        chk("post_flush_empty", 32'(rx_empty), 1);

`ifdef UART_BUF_RX_TIMEOUT_EN
        rx_tmo_cycles = 16'd10;
        rx_we = 1; rx_wdata = 10'h0A5;
        step();
        rx_we = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("tmo_rise", 32'(int_rx_timeout), (k == 10) ? 1 : 0);
        end
        step();
        chk("tmo_sticky", 32'(int_rx_timeout), 1);
        rx_re = 1;
        step();
        rx_re = 0;
        chk("tmo_rd_clr", 32'(int_rx_timeout), 0);
        chk("tmo_rd_data", 32'(rx_rdata), 32'h0A5);
`endif
        rx_tmo_cycles = '0;
        rx_we = 1; rx_wdata = 10'h05A;
        step();
        rx_we = 0;
        for (int k = 0; k < 20; k++) step();
        chk("tmo_disabled", 32'(int_rx_timeout), 0);
        rx_re = 1;
        step();
        rx_re = 0;
        chk("tmo_dis_data", 32'(rx_rdata), 32'h05A);

        // asynchronous reset mid-transfer
        tx_we = 1; tx_wdata = 10'h011;
        step();
        step();
        tx_we = 0;
        chk("tx_level2", 32'(tx_level), 2);
        #3;
        rstn = 1'b0;
        #1;
        chk("async_rst_level", 32'(tx_level), 0);
        chk("async_rst_empty", 32'(tx_empty), 1);
        chk("async_rst_rdata", 32'(rx_rdata), 0);
        @(negedge clk);
        rstn = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_buffer_ctrl.md
# uart_buffer_ctrl

Parametrised TX/RX data buffer for the UART. It holds two internal synchronous FIFOs of configurable width and depth. It adds flush, sticky overflow/underflow error flags, programmable-direction watermark flags and an optional RX character-timeout detector. It sits between the UART register file and the TX/RX protocol engines:
- the TX FIFO is written by the registers and read by the TX engine;
- the RX FIFO is written by the RX engine and read by the registers.

## Interface
Parameters:
- DATA_WIDTH, 10, FIFO word width (data plus parity/frame-error bits)
- ADDR_WIDTH, 4, FIFO address width; depth = 2**ADDR_WIDTH
- TMO_WIDTH, 16, width of RX timeout counter and threshold

Ports. One clock. Reset is asynchronous and active-low.
- clk  in  1  single clock for both FIFOs and all logic
- rstn  in  1  asynchronous active-low reset
- tx_flush  in  1  empty TX FIFO (single-cycle pulse)
- rx_flush  in  1  empty RX FIFO (single-cycle pulse)
- tx_we / rx_we  in  1  write request
- tx_re / rx_re  in  1  read request
- tx_wdata / rx_wdata  in  DATA_WIDTH  write data
- tx_rdata / rx_rdata  out  DATA_WIDTH  registered read data
- tx_level / rx_level  out  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH
- tx_empty, tx_full, rx_empty, rx_full  out  1  status flags
- tx_watermark / rx_watermark  in  ADDR_WIDTH+1  warning thresholds
- err_clr  in  4  write-1-to-clear, bit order {rx_udf, rx_ovf, tx_udf, tx_ovf}
- err_status  out  4  sticky error flags, same bit order as err_clr
- rx_tmo_cycles  in  TMO_WIDTH  idle-cycle threshold; 0 disables the detector
- rx_tmo_clr  in  1  clear the RX timeout flag
- int_rx_noempty, int_rx_warning, int_tx_empty, int_tx_warning, int_rx_timeout  out  1  interrupt status (level)

## Operation
- Each FIFO has:
  - RAM of 2**ADDR_WIDTH x DATA_WIDTH;
  - write and read pointers of ADDR_WIDTH bits that wrap modulo depth;
  - a level counter of ADDR_WIDTH+1 bits.
- empty = (level == 0). full = (level == 2**ADDR_WIDTH).
- Write is accepted when we=1 and (not full, or re accepted in the same cycle).
- Read is accepted when re=1 and not empty.
- Write while full with no read: data dropped, level unchanged, the ovf bit is set.
- Read while empty: rdata held, the udf bit is set. A simultaneous write into an empty FIFO is still accepted.
- Simultaneous accepted read and write: level is unchanged and both pointers advance.
- Flush has priority over we/re in that cycle:
  - pointers and level go to 0;
  - a concurrent write is dropped and does not set ovf;
  - rdata and err_status are unchanged.
- err_status bits are sticky.
  - A bit is set on an error event and cleared by err_clr.
  - If a set event and a clear occur in the same cycle, set wins.
- int_rx_noempty = ~rx_empty.
- int_tx_empty = tx_empty.
- int_rx_warning = (rx_level >= rx_watermark).
- int_tx_warning = (tx_level <= tx_watermark). This is a refill request, the inverse sense of the RX warning.
- Watermark inputs are compared at full ADDR_WIDTH+1 width, unsigned.
  - A watermark greater than depth means int_rx_warning is never set and int_tx_warning is always set.
- RX timeout (see Configuration):
  - An idle counter clears when any of these holds: rx_empty, rx write accepted, rx read accepted, rx_flush, rx_tmo_cycles==0.
  - Otherwise the counter increments, saturating at all-ones.
  - The int_rx_timeout flag sets when the counter reaches rx_tmo_cycles.
  - The flag is cleared by rx_tmo_clr, by an accepted rx read, or by rx_flush.
  - If a set and a clear occur in the same cycle, clear wins.

## Timing
- Reset values:
  - pointers, levels, rdata, err_status, idle counter and int_rx_timeout are all 0;
  - tx_empty = rx_empty = 1;
  - int_tx_empty = 1 and int_tx_warning = 1 (level 0 <= any watermark).
- Reset is asynchronous and may occur mid-transfer. FIFO contents are not cleared; only pointers and level reset.
- Read latency is 1 cycle: rdata is valid on the edge after an accepted re.
- Level, empty, full and warning flags update on the same edge as the accepted operation. They are combinational from registered level.
- A write followed by a read on the next cycle is legal. There is no fall-through: a write to an empty FIFO is readable from the next cycle.
- err_status updates on the edge following the error cycle.
- Timeout: with rx_tmo_cycles=N and the RX FIFO non-empty, int_rx_timeout rises N cycles after the last clearing event.

## Configuration
- Macro: UART_BUF_RX_TIMEOUT_EN.
- Defined: the idle counter and int_rx_timeout logic are present as described.
- Undefined: the counter is removed, int_rx_timeout is tied to 0, and rx_tmo_cycles and rx_tmo_clr are ignored.

## Test plan
- Reset, then write 16 words 0x001..0x010 to TX (ADDR_WIDTH=4):
  - tx_full=1 and tx_level=16;
  - a 17th write sets err_status[0];
  - 16 reads return 0x001..0x010 in order, with tx_empty=1 at the end.
- RX with level 15, then simultaneous rx_we and rx_re for 20 cycles → level stays 15, no ovf, data in order across pointer wrap.
- rx_re while empty → err_status[3]=1, rx_rdata unchanged. err_clr=4'b1000 clears the flag one edge later.
- TX level 5 with tx_watermark=4 → int_tx_warning=0. After 1 read → 1.
- rx_watermark=8 → int_rx_warning rises on the edge of the 8th write.
- rx_flush asserted together with rx_we at level 3 → level 0, rx_empty=1, no ovf.
- Macro defined, rx_tmo_cycles=10, one RX write then idle:
  - int_rx_timeout rises 10 cycles after the write edge;
  - an rx read clears it;
  - with rx_tmo_cycles=0 the flag never rises.
